// File: rtl/cpu_pkg.sv
// cpu_pkg: shared register-file geometry and context-engine state encoding
package cpu_pkg;
    localparam int RF_DATA_W = 16;
    localparam int RF_ADDR_W = 3;
    localparam int RF_NREGS  = 8;
    typedef enum logic [2:0] {IDLE, SAVE, SAVE_DRAIN, RESTORE, FINISH} ctx_state_t;
endpackage

// File: rtl/regfile_ctx_engine_if.sv
// regfile_ctx_engine_if: control, register-file port and save/restore streams of the context engine
interface regfile_ctx_engine_if #(
    parameter int DATA_W = cpu_pkg::RF_DATA_W,
    parameter int ADDR_W = cpu_pkg::RF_ADDR_W
);
    logic              save_req;
    logic              restore_req;
    logic              busy;
    logic              done;
    logic [ADDR_W-1:0] rf_rd_addr;
    logic [DATA_W-1:0] rf_rd_data;
    logic              rf_wr_en;
    logic [ADDR_W-1:0] rf_wr_addr;
    logic [DATA_W-1:0] rf_wr_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_last;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    modport master (
        input  save_req, restore_req, rf_rd_data, out_ready, in_valid, in_data,
        output busy, done, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
        output out_valid, out_data, out_last, in_ready
    );
    modport slave (
        output save_req, restore_req, rf_rd_data, out_ready, in_valid, in_data,
        input  busy, done, rf_rd_addr, rf_wr_en, rf_wr_addr, rf_wr_data,
        input  out_valid, out_data, out_last, in_ready
    );
endinterface

// File: rtl/ctx_out_reg.sv
// ctx_out_reg: single-entry valid/ready output register carrying data and a last flag
module ctx_out_reg #(
    parameter int DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              ld,
    input  logic [DATA_W-1:0] ld_data,
    input  logic              ld_last,
    output logic              ld_rdy,
    output logic              valid,
    input  logic              ready,
    output logic [DATA_W-1:0] data,
    output logic              last
);
    assign ld_rdy = !valid || ready;
    always_ff @(posedge clk) begin
        if (rst) begin
            valid <= 1'b0;
            data  <= '0;
            last  <= 1'b0;
        end else if (ld_rdy) begin
            valid <= ld;
            if (ld) begin
                data <= ld_data;
                last <= ld_last;
            end
        end
    end
endmodule

// File: rtl/regfile_ctx_engine.sv
// regfile_ctx_engine: streams R0..R7 out on save and writes eight streamed words back on restore
module regfile_ctx_engine import cpu_pkg::*; #(
    parameter int DATA_W = RF_DATA_W,
    parameter int ADDR_W = RF_ADDR_W,
    parameter int NREGS  = RF_NREGS
) (
    input  logic                 clk,
    input  logic                 rst,
    regfile_ctx_engine_if.master bus
);
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(NREGS - 1);
    ctx_state_t      state;
    logic [ADDR_W:0] idx;
    logic            ld, ld_rdy, last_word;
    assign ld             = state == SAVE;
    assign last_word      = idx == LAST_IDX;
    assign bus.rf_rd_addr = ld ? idx[ADDR_W-1:0] : '0;
    ctx_out_reg #(.DATA_W(DATA_W)) u_out (
        .clk     (clk),
        .rst     (rst),
        .ld      (ld),
        .ld_data (bus.rf_rd_data),
        .ld_last (last_word),
        .ld_rdy  (ld_rdy),
        .valid   (bus.out_valid),
        .ready   (bus.out_ready),
        .data    (bus.out_data),
        .last    (bus.out_last)
    );
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            idx            <= '0;
            bus.busy       <= 1'b0;
            bus.done       <= 1'b0;
            bus.in_ready   <= 1'b0;
            bus.rf_wr_en   <= 1'b0;
            bus.rf_wr_addr <= '0;
            bus.rf_wr_data <= '0;
        end else begin
            bus.done     <= 1'b0;
            bus.rf_wr_en <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.save_req) begin
                        state    <= SAVE;
                        idx      <= '0;
                        bus.busy <= 1'b1;
                    end else if (bus.restore_req) begin
                        state        <= RESTORE;
                        idx          <= '0;
                        bus.busy     <= 1'b1;
                        bus.in_ready <= 1'b1;
                    end
                end
                SAVE: begin
                    if (ld_rdy) begin
                        idx <= idx + 1'b1;
                        if (last_word) state <= SAVE_DRAIN;
                    end
                end
                SAVE_DRAIN: begin
                    if (bus.out_valid && bus.out_ready && bus.out_last) begin
                        state    <= FINISH;
                        bus.done <= 1'b1;
                    end
                end
                RESTORE: begin
                    if (bus.in_valid && bus.in_ready) begin
                        bus.rf_wr_en   <= 1'b1;
                        bus.rf_wr_addr <= idx[ADDR_W-1:0];
                        bus.rf_wr_data <= bus.in_data;
                        idx            <= idx + 1'b1;
                        if (last_word) begin
                            state        <= FINISH;
                            bus.done     <= 1'b1;
                            bus.in_ready <= 1'b0;
                        end
                    end
                end
                FINISH: begin
                    state    <= IDLE;
                    bus.busy <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_regfile_ctx_engine.sv
// tb_regfile_ctx_engine: directed bench with a behavioural register file around the context engine
module tb_regfile_ctx_engine;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        preload = 1'b1;
    logic [15:0] rf [8];
    logic [15:0] exp_rf [8];
    int          n_cmp = 0;
    int          n_err = 0;
    int          wr_cnt = 0;
    int          wr_base;
    int          k;
    int          hs_cnt;

    regfile_ctx_engine_if bus ();

    regfile_ctx_engine dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    assign bus.rf_rd_data = rf[bus.rf_rd_addr];

    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < 8; i++) rf[i] <= 16'(16'h1111 * (i + 1));
        end else if (bus.rf_wr_en) begin
            rf[bus.rf_wr_addr] <= bus.rf_wr_data;
        end
        if (bus.rf_wr_en) wr_cnt <= wr_cnt + 1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_exp(input logic [15:0] base, input logic [15:0] stride);
        for (int i = 0; i < 8; i++) exp_rf[i] = 16'(base + stride * i);
    endtask

    // Runs one save with optional 1,0,0,1 backpressure and an optional restore_req poke mid-save;
    // returns in the cycle where done should be high.
    task automatic save_stream(input bit toggle, input bit both, input bit poke);
        logic        held;
        logic [15:0] hold_d;
        bit          pat [4];
        pat = '{1'b1, 1'b0, 1'b0, 1'b1};
        held = 1'b0;
        hold_d = '0;
        bus.save_req = 1'b1;
        bus.restore_req = both;
        step();
        bus.save_req = 1'b0;
        bus.restore_req = 1'b0;
        chk("save_busy", bus.busy, 1);
        k = 0;
        for (int c = 0; c < 60 && k < 8; c++) begin
            bus.out_ready = toggle ? pat[c % 4] : 1'b1;
            bus.restore_req = poke && c == 2;
            chk("save_no_early_done", bus.done, 0);
            chk("save_no_wr", bus.rf_wr_en, 0);
            if (bus.out_valid) begin
                if (held) chk("save_stall_hold", bus.out_data, hold_d);
                if (bus.out_ready) begin
                    chk("save_word", bus.out_data, exp_rf[k]);
                    chk("save_last", bus.out_last, k == 7);
                    k++;
                end
                held = !bus.out_ready;
                hold_d = bus.out_data;
            end
            step();
        end
        bus.restore_req = 1'b0;
        bus.out_ready = 1'b1;
        chk("save_word_count", k, 8);
        chk("save_done", bus.done, 1);
        chk("save_valid_off", bus.out_valid, 0);
        chk("save_in_ready_off", bus.in_ready, 0);
    endtask

    initial begin
        bus.save_req = 1'b0;
        bus.restore_req = 1'b0;
        bus.out_ready = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_data = '0;
        step();
        step();
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        chk("rst_out_valid", bus.out_valid, 0);
        chk("rst_in_ready", bus.in_ready, 0);
        chk("rst_wr_en", bus.rf_wr_en, 0);
        chk("rst_rd_addr", bus.rf_rd_addr, 0);
        rst = 1'b0;
        preload = 1'b0;

        // Save with ready held: exact cycle timing
        set_exp(16'h1111, 16'h1111);
        bus.save_req = 1'b1;
        step();
        bus.save_req = 1'b0;
        chk("t1_busy_c1", bus.busy, 1);
        chk("t1_valid_c1", bus.out_valid, 0);
        for (int i = 0; i < 8; i++) begin
            step();
            chk("t1_valid", bus.out_valid, 1);
            chk("t1_data", bus.out_data, exp_rf[i]);
            chk("t1_last", bus.out_last, i == 7);
            chk("t1_done_low", bus.done, 0);
        end
        step();
        chk("t1_done_c10", bus.done, 1);
        chk("t1_busy_c10", bus.busy, 1);
        chk("t1_valid_c10", bus.out_valid, 0);
        step();
        chk("t1_done_c11", bus.done, 0);
        chk("t1_busy_c11", bus.busy, 0);
        chk("t1_no_writes", wr_cnt, 0);

        // Save under 1,0,0,1 backpressure
        save_stream(1'b1, 1'b0, 1'b0);
        step();
        chk("t2_done_single", bus.done, 0);
        chk("t2_no_writes", wr_cnt, 0);

        // Restore with in_valid gaps
        wr_base = wr_cnt;
        bus.restore_req = 1'b1;
        step();
        bus.restore_req = 1'b0;
        chk("t3_in_ready_c1", bus.in_ready, 1);
        hs_cnt = 0;
        for (int c = 0; c < 40 && hs_cnt < 8; c++) begin
            bit hs;
            bus.in_valid = (c % 3) != 1;
            bus.in_data = 16'(16'hA000 + hs_cnt);
            hs = bus.in_valid && bus.in_ready;
            step();
            if (hs) hs_cnt++;
        end
        bus.in_valid = 1'b0;
        chk("t3_hs_count", hs_cnt, 8);
        chk("t3_in_ready_off", bus.in_ready, 0);
        chk("t3_done", bus.done, 1);
        step();
        chk("t3_done_single", bus.done, 0);
        set_exp(16'hA000, 16'h0001);
        for (int i = 0; i < 8; i++) chk("t3_rf", rf[i], exp_rf[i]);
        chk("t3_wr_pulses", wr_cnt - wr_base, 8);

        // Simultaneous requests and a restore poke mid-save: both must be saves
        wr_base = wr_cnt;
        save_stream(1'b0, 1'b1, 1'b0);
        step();
        save_stream(1'b1, 1'b0, 1'b1);
        step();
        chk("t4_no_writes", wr_cnt - wr_base, 0);
        chk("t4_idle", bus.busy, 0);

        // Reset after the third restore handshake
        preload = 1'b1;
        step();
        preload = 1'b0;
        bus.restore_req = 1'b1;
        step();
        bus.restore_req = 1'b0;
        bus.in_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            bus.in_data = 16'(16'hB000 + i);
            step();
        end
        bus.in_data = 16'hB003;
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.in_valid = 1'b0;
        chk("t5_busy", bus.busy, 0);
        chk("t5_done", bus.done, 0);
        chk("t5_out_valid", bus.out_valid, 0);
        chk("t5_out_last", bus.out_last, 0);
        chk("t5_out_data", bus.out_data, 0);
        chk("t5_in_ready", bus.in_ready, 0);
        chk("t5_wr_en", bus.rf_wr_en, 0);
        chk("t5_wr_addr", bus.rf_wr_addr, 0);
        chk("t5_wr_data", bus.rf_wr_data, 0);
        chk("t5_rd_addr", bus.rf_rd_addr, 0);
        step();
        chk("t5_no_done", bus.done, 0);
        exp_rf = '{16'hB000, 16'hB001, 16'hB002, 16'h4444, 16'h5555, 16'h6666, 16'h7777, 16'h8888};
        for (int i = 0; i < 8; i++) chk("t5_rf", rf[i], exp_rf[i]);
        save_stream(1'b0, 1'b0, 1'b0);

        // Back-to-back save requested in the cycle after done
        step();
        chk("t6_idle", bus.busy, 0);
        save_stream(1'b1, 1'b0, 1'b0);
        step();
        chk("t6_done_single", bus.done, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
